time_display: RTL and testbench

Downstream consumer of the clock's time-keeping counter. Takes the binary seconds/minutes/hours values, converts each to two BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives the six active-low seven-segment HEX displays of the MAX 10 board. Outputs change only at a single commit point, so all six displays always show one coherent time value.

---
 rtl/time_display.sv | 181 ++++++++++++++++++
 tb/tb_time_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/time_display.sv
// Binary seconds/minutes/hours to six active-low seven-segment digits.
// A serial double-dabble engine converts one bit per cycle; all six displays update together in COMMIT.
module time_display #(
    parameter logic [31:0] CLOCK_FREQ    = 32'd50_000_000,
    parameter logic        BLANK_HOUR_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_seconds,
    input  logic [5:0] i_minutes,
    input  logic [6:0] i_hours,
    output logic [7:0] o_hex0,
    output logic [7:0] o_hex1,
    output logic [7:0] o_hex2,
    output logic [7:0] o_hex3,
    output logic [7:0] o_hex4,
    output logic [7:0] o_hex5,
    output logic       o_busy,
    output logic       o_update
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state_reg, state_next;
    logic [18:0] snap_reg;
    logic        force_reg;
    logic [1:0]  field_reg;
    logic [2:0]  bit_reg;
    logic [11:0] bcd_reg;
    logic [7:0]  sec_bcd_reg, min_bcd_reg, hr_bcd_reg;
    logic        hr_over_reg;

    logic [18:0] cur_in;
    logic        start;
    logic [6:0]  field_val;
    logic        in_bit;
    logic [11:0] bcd_adj;
    logic [12:0] bcd_shift;
    logic        field_done;
    logic        dp;
    logic        hr_tens_blank;
    logic [7:0]  disp0, disp1, disp2, disp3, disp4, disp5;

    // The clock frequency is carried only to keep the parameter set aligned with the counter stage.
    if (CLOCK_FREQ == 32'd0) begin : g_freq_unset
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign cur_in = {i_hours, i_minutes, i_seconds};
    assign start  = (state_reg == IDLE) && (force_reg || (cur_in != snap_reg));
    assign o_busy = (state_reg != IDLE);

    always_comb begin
        field_val = snap_reg[18:12];
        case (field_reg)
            2'd0:    field_val = {1'b0, snap_reg[5:0]};
            2'd1:    field_val = {1'b0, snap_reg[11:6]};
            default: field_val = snap_reg[18:12];
        endcase
    end

    // MSB first: bit_reg 0 selects bit 6 of the zero-extended field.
    assign in_bit = field_val[3'd6 - bit_reg];

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_adjust
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                  : bcd_reg[4*gi +: 4];
    end

    assign bcd_shift  = {bcd_adj, in_bit};
    assign field_done = (bit_reg == 3'd6);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (field_done && (field_reg == 2'd2)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Separator dots blink with the parity of the committed seconds value.
    assign dp            = snap_reg[0];
    assign hr_tens_blank = BLANK_HOUR_LZ && !hr_over_reg && (hr_bcd_reg[7:4] == 4'd0);

    always_comb begin
        disp0 = {1'b1, seg7(sec_bcd_reg[3:0])};
        disp1 = {1'b1, seg7(sec_bcd_reg[7:4])};
        disp2 = {dp,   seg7(min_bcd_reg[3:0])};
        disp3 = {1'b1, seg7(min_bcd_reg[7:4])};
        disp4 = hr_over_reg ? {dp, 7'h3F} : {dp, seg7(hr_bcd_reg[3:0])};
        if (hr_over_reg)        disp5 = 8'hBF;
        else if (hr_tens_blank) disp5 = 8'hFF;
        else                    disp5 = {1'b1, seg7(hr_bcd_reg[7:4])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_reg    <= '0;
            force_reg   <= 1'b1;
            field_reg   <= '0;
            bit_reg     <= '0;
            bcd_reg     <= '0;
            sec_bcd_reg <= '0;
            min_bcd_reg <= '0;
            hr_bcd_reg  <= '0;
            hr_over_reg <= 1'b0;
            o_hex0      <= 8'hFF;
            o_hex1      <= 8'hFF;
            o_hex2      <= 8'hFF;
            o_hex3      <= 8'hFF;
            o_hex4      <= 8'hFF;
            o_hex5      <= 8'hFF;
            o_update    <= 1'b0;
        end else begin
            o_update <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        snap_reg  <= cur_in;
                        force_reg <= 1'b0;
                        field_reg <= '0;
                        bit_reg   <= '0;
                        bcd_reg   <= '0;
                    end
                end
                CONV: begin
                    if (field_done) begin
                        bcd_reg   <= '0;
                        bit_reg   <= '0;
                        field_reg <= field_reg + 2'd1;
                        case (field_reg)
                            2'd0: sec_bcd_reg <= bcd_shift[7:0];
                            2'd1: min_bcd_reg <= bcd_shift[7:0];
                            default: begin
                                hr_bcd_reg  <= bcd_shift[7:0];
                                hr_over_reg <= |bcd_shift[12:8];
                            end
                        endcase
                    end else begin
                        bcd_reg <= bcd_shift[11:0];
                        bit_reg <= bit_reg + 3'd1;
                    end
                end
                COMMIT: begin
                    o_hex0   <= disp0;
                    o_hex1   <= disp1;
                    o_hex2   <= disp2;
                    o_hex3   <= disp3;
                    o_hex4   <= disp4;
                    o_hex5   <= disp5;
                    o_update <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_display.sv
// Self-checking bench for time_display: directed and random times compared against an arithmetic
// digit model, with both leading-zero settings instantiated side by side.
module tb_time_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [6:0] hr  = '0;

    logic [5:0][7:0] a_hex, b_hex;
    logic a_busy, a_upd, b_busy, b_upd;

    int errors = 0;
    int checks = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    time_display #(.BLANK_HOUR_LZ(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_seconds(sec), .i_minutes(min), .i_hours(hr),
        .o_hex0(a_hex[0]), .o_hex1(a_hex[1]), .o_hex2(a_hex[2]), .o_hex3(a_hex[3]),
        .o_hex4(a_hex[4]), .o_hex5(a_hex[5]), .o_busy(a_busy), .o_update(a_upd)
    );

    time_display #(.BLANK_HOUR_LZ(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_seconds(sec), .i_minutes(min), .i_hours(hr),
        .o_hex0(b_hex[0]), .o_hex1(b_hex[1]), .o_hex2(b_hex[2]), .o_hex3(b_hex[3]),
        .o_hex4(b_hex[4]), .o_hex5(b_hex[5]), .o_busy(b_busy), .o_update(b_upd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int h, input int m, input int s, input bit lz, input int idx);
        logic [7:0] dpm;
        logic [7:0] r;
        dpm = (s % 2 == 0) ? 8'h7F : 8'hFF;
        case (idx)
            0:       r = seg_tab[s % 10];
            1:       r = seg_tab[s / 10];
            2:       r = seg_tab[m % 10] & dpm;
            3:       r = seg_tab[m / 10];
            4:       r = (h > 99) ? (8'hBF & dpm) : (seg_tab[h % 10] & dpm);
            default: r = (h > 99) ? 8'hBF : ((lz && h < 10) ? 8'hFF : seg_tab[h / 10]);
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input string tag, input int h, input int m, input int s);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s lz0 hex%0d", tag, i), {24'd0, a_hex[i]}, {24'd0, model(h, m, s, 1'b0, i)});
            check($sformatf("%s lz1 hex%0d", tag, i), {24'd0, b_hex[i]}, {24'd0, model(h, m, s, 1'b1, i)});
        end
        $display("txn %s h=%0d m=%0d s=%0d hex5..0=%h %h %h %h %h %h lz1_hex5=%h", tag, h, m, s,
                 a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0], b_hex[5]);
    endtask

    task automatic drive(input int h, input int m, input int s);
        @(posedge clk);
        #1;
        hr  = h[6:0];
        min = m[5:0];
        sec = s[5:0];
    endtask

    // Counts edges from the current point until o_update, then checks latency, busy span and pulse width.
    task automatic wait_commit(input string tag);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (a_busy) busy_cnt++;
            if (a_upd) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, 23);
        check({tag, " busy_cycles"}, busy_cnt, 22);
        check({tag, " lz1_update"}, {31'd0, b_upd}, 32'd1);
    endtask

    task automatic pulse_gone(input string tag);
        @(posedge clk);
        #1;
        check({tag, " update_width"}, {31'd0, a_upd}, 32'd0);
    endtask

    initial begin
        int upd_cnt;
        int h, m, s;

        // Reset state
        #12;
        for (int i = 0; i < 6; i++) check($sformatf("reset hex%0d", i), {24'd0, a_hex[i]}, 32'hFF);
        check("reset busy", {31'd0, a_busy}, 32'd0);
        check("reset update", {31'd0, a_upd}, 32'd0);
        $display("txn reset hex5..0=%h %h %h %h %h %h", a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0]);

        // First edge after release converts even with all-zero inputs
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_commit("post_reset");
        check_display("post_reset", 0, 0, 0);
        pulse_gone("post_reset");

        // Unchanged inputs must not trigger a conversion
        upd_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (a_upd || a_busy) upd_cnt++;
        end
        check("idle no_update", upd_cnt, 0);
        $display("txn idle_hold activity=%0d", upd_cnt);

        drive(9, 59, 58);  wait_commit("t_9_59_58");  check_display("t_9_59_58", 9, 59, 58);  pulse_gone("t_9_59_58");
        drive(9, 59, 59);  wait_commit("t_9_59_59");  check_display("t_9_59_59", 9, 59, 59);  pulse_gone("t_9_59_59");
        drive(127, 0, 1);  wait_commit("t_127_0_1");  check_display("t_127_0_1", 127, 0, 1);
        drive(100, 0, 2);  wait_commit("t_100_0_2");  check_display("t_100_0_2", 100, 0, 2);
        drive(99, 9, 0);   wait_commit("t_99_9_0");   check_display("t_99_9_0", 99, 9, 0);
        drive(7, 5, 3);    wait_commit("t_7_5_3");    check_display("t_7_5_3", 7, 5, 3);
        drive(10, 0, 0);   wait_commit("t_10_0_0");   check_display("t_10_0_0", 10, 0, 0);

        // Input change during conversion: first commit shows the old value, a second follows
        drive(12, 34, 10);
        repeat (6) @(posedge clk);
        #1;
        sec = 6'd11;
        upd_cnt = 0;
        for (int n = 7; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (a_upd) begin
                upd_cnt++;
                if (upd_cnt == 1) begin
                    check("midchange first_at", n, 23);
                    check_display("midchange_first", 12, 34, 10);
                end else if (upd_cnt == 2) begin
                    check("midchange second_at", n, 46);
                    check_display("midchange_second", 12, 34, 11);
                end
            end
        end
        check("midchange pulses", upd_cnt, 2);

        // Reset during the minutes field aborts and blanks immediately
        drive(20, 40, 30);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) check($sformatf("midreset hex%0d", i), {24'd0, a_hex[i]}, 32'hFF);
        check("midreset busy", {31'd0, a_busy}, 32'd0);
        $display("txn midreset hex5..0=%h %h %h %h %h %h", a_hex[5], a_hex[4], a_hex[3], a_hex[2], a_hex[1], a_hex[0]);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_commit("after_reset");
        check_display("after_reset", 20, 40, 30);

        // Random times across the full accepted ranges
        for (int k = 0; k < 8; k++) begin
            h = int'($urandom_range(0, 127));
            m = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 63));
            if (h == int'(hr) && m == int'(min) && s == int'(sec)) s = (s + 1) % 64;
            drive(h, m, s);
            wait_commit($sformatf("rand%0d", k));
            check_display($sformatf("rand%0d", k), h, m, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
